// File: rtl/obstacles_pkg.sv
// rtl/obstacles_pkg.sv - level geometry tables, border limits and rectangle hit test
package obstacles_pkg;

  localparam int TBL_N_OBST     = 8;
  localparam int TBL_N_LVL      = 3;
  localparam int BORDER_TOP_DEF = 40;
  localparam int BORDER_BOT_DEF = 580;
  localparam logic [10:0] V_LAST = 11'd599;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [10:0] w;
    logic [10:0] h;
    logic        valid;
  } rect_t;

  localparam rect_t NO_RECT = '{x: 11'd0, y: 11'd0, w: 11'd0, h: 11'd0, valid: 1'b0};

  function automatic rect_t mk_rect(input int x, input int y, input int w, input int h);
    rect_t r;
    r.x = 11'(x);
    r.y = 11'(y);
    r.w = 11'(w);
    r.h = 11'(h);
    r.valid = 1'b1;
    return r;
  endfunction

  localparam rect_t LVL_TBL [TBL_N_LVL][TBL_N_OBST] = '{
    '{mk_rect(200, 250, 150, 20), mk_rect(450, 150, 150, 20),
      mk_rect(200, 530, 70, 60),  mk_rect(280, 490, 60, 100),
      NO_RECT, NO_RECT, NO_RECT, NO_RECT},
    '{mk_rect(100, 200, 300, 20), mk_rect(500, 300, 200, 20),
      mk_rect(300, 450, 40, 130), mk_rect(600, 100, 20, 200),
      NO_RECT, NO_RECT, NO_RECT, NO_RECT},
    '{mk_rect(0, 300, 350, 20),   mk_rect(450, 300, 350, 20),
      mk_rect(380, 150, 40, 100), NO_RECT,
      NO_RECT, NO_RECT, NO_RECT, NO_RECT}
  };

  localparam rect_t PAD_TBL [TBL_N_LVL] = '{
    mk_rect(630, 550, 115, 20),
    mk_rect(50, 560, 100, 20),
    mk_rect(380, 560, 60, 20)
  };

  // Ends are formed in 12 bits so x+w cannot wrap past 2047.
  function automatic logic in_rect(input rect_t r, input logic [10:0] h, input logic [10:0] v);
    logic [11:0] x_end;
    logic [11:0] y_end;
    x_end = {1'b0, r.x} + {1'b0, r.w};
    y_end = {1'b0, r.y} + {1'b0, r.h};
    return r.valid && (h >= r.x) && ({1'b0, h} < x_end) &&
           (v >= r.y) && ({1'b0, v} < y_end);
  endfunction

endpackage

// File: rtl/obst_hit_acc.sv
// rtl/obst_hit_acc.sv - per-frame crash/landing accumulation and sticky flag publish
module obst_hit_acc (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic in_obst,
  input  logic in_pad,
  input  logic in_obj,
  input  logic vblnk,
  input  logic flag_clr,
  output logic crash_flag,
  output logic land_flag,
  output logic frame_done
);

  logic vblnk_d;
  logic crash_acc;
  logic land_acc;
  logic crash_hit;
  logic land_hit;
  logic publish;

  assign crash_hit = active && in_obst && in_obj;
  assign land_hit  = active && in_pad && in_obj && !in_obst;
  assign publish   = vblnk && !vblnk_d;

  // A clear landing on a publish cycle is overridden by the freshly closed frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_d    <= 1'b0;
      crash_acc  <= 1'b0;
      land_acc   <= 1'b0;
      crash_flag <= 1'b0;
      land_flag  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      vblnk_d    <= vblnk;
      frame_done <= publish;
      if (publish) begin
        crash_acc  <= 1'b0;
        land_acc   <= 1'b0;
        crash_flag <= (crash_flag && !flag_clr) || crash_acc || crash_hit;
        land_flag  <= (land_flag && !flag_clr) || land_acc || land_hit;
      end else begin
        crash_acc <= crash_acc || crash_hit;
        land_acc  <= land_acc || land_hit;
        if (flag_clr) begin
          crash_flag <= 1'b0;
          land_flag  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/draw_obstacles_tbl.sv
// rtl/draw_obstacles_tbl.sv - two-stage table-driven obstacle/pad overlay with hit reporting
module draw_obstacles_tbl
  import obstacles_pkg::*;
#(
  parameter int          N_OBST     = TBL_N_OBST,
  parameter int          N_LVL      = TBL_N_LVL,
  parameter int          LVL_W      = 3,
  parameter logic [11:0] OBST_RGB   = 12'h000,
  parameter logic [11:0] PAD_RGB    = 12'h0F0,
  parameter int          BORDER_TOP = BORDER_TOP_DEF,
  parameter int          BORDER_BOT = BORDER_BOT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LVL_W-1:0] lvl,
  input  logic [10:0]      obj_x,
  input  logic [10:0]      obj_y,
  input  logic [6:0]       obj_w,
  input  logic [6:0]       obj_h,
  input  logic [10:0]      hcount_in,
  input  logic [10:0]      vcount_in,
  input  logic             hsync_in,
  input  logic             hblnk_in,
  input  logic             vsync_in,
  input  logic             vblnk_in,
  input  logic [11:0]      rgb_in,
  output logic [10:0]      hcount_out,
  output logic [10:0]      vcount_out,
  output logic             hsync_out,
  output logic             hblnk_out,
  output logic             vsync_out,
  output logic             vblnk_out,
  output logic [11:0]      rgb_out,
  output logic             crash_flag,
  output logic             land_flag,
  output logic             frame_done,
  input  logic             flag_clr
);

  localparam logic [10:0] B_TOP = 11'(BORDER_TOP);
  localparam logic [10:0] B_BOT = 11'(BORDER_BOT);

  logic [LVL_W-1:0] lvl_q;
  logic             vblnk_d;
  logic             lvl_ok;
  logic             rect_hit;
  logic             pad_hit;
  logic             border_hit;
  rect_t            obj_r;

  logic [10:0] s1_hcount;
  logic [10:0] s1_vcount;
  logic        s1_hsync;
  logic        s1_hblnk;
  logic        s1_vsync;
  logic        s1_vblnk;
  logic [11:0] s1_rgb;
  logic        s1_in_obst;
  logic        s1_in_pad;
  logic        s1_in_obj;
  logic        s1_active;

  // Unmatched level codes leave lvl_ok low, which turns the stage into a pass-through.
  always_comb begin
    lvl_ok   = 1'b0;
    rect_hit = 1'b0;
    pad_hit  = 1'b0;
    for (int l = 0; l < N_LVL; l++) begin
      if (lvl_q == LVL_W'(l + 1)) begin
        lvl_ok  = 1'b1;
        pad_hit = in_rect(PAD_TBL[l], hcount_in, vcount_in);
        for (int i = 0; i < N_OBST; i++)
          rect_hit = rect_hit | in_rect(LVL_TBL[l][i], hcount_in, vcount_in);
      end
    end
  end

  assign border_hit = lvl_ok &&
                      ((vcount_in < B_TOP) || ((vcount_in >= B_BOT) && (vcount_in <= V_LAST)));

  assign obj_r = '{x: obj_x, y: obj_y, w: {4'd0, obj_w}, h: {4'd0, obj_h},
                   valid: (obj_w != 7'd0) && (obj_h != 7'd0)};

  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q      <= '0;
      vblnk_d    <= 1'b0;
      s1_hcount  <= '0;
      s1_vcount  <= '0;
      s1_hsync   <= 1'b0;
      s1_hblnk   <= 1'b0;
      s1_vsync   <= 1'b0;
      s1_vblnk   <= 1'b0;
      s1_rgb     <= '0;
      s1_in_obst <= 1'b0;
      s1_in_pad  <= 1'b0;
      s1_in_obj  <= 1'b0;
    end else begin
      vblnk_d <= vblnk_in;
      if (vblnk_in && !vblnk_d)
        lvl_q <= lvl;
      s1_hcount  <= hcount_in;
      s1_vcount  <= vcount_in;
      s1_hsync   <= hsync_in;
      s1_hblnk   <= hblnk_in;
      s1_vsync   <= vsync_in;
      s1_vblnk   <= vblnk_in;
      s1_rgb     <= rgb_in;
      s1_in_obst <= border_hit || rect_hit;
      s1_in_pad  <= pad_hit;
      s1_in_obj  <= in_rect(obj_r, hcount_in, vcount_in);
    end
  end

  assign s1_active = !s1_hblnk && !s1_vblnk;

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= s1_hcount;
      vcount_out <= s1_vcount;
      hsync_out  <= s1_hsync;
      hblnk_out  <= s1_hblnk;
      vsync_out  <= s1_vsync;
      vblnk_out  <= s1_vblnk;
      if (s1_active && s1_in_obst)
        rgb_out <= OBST_RGB;
      else if (s1_active && s1_in_pad)
        rgb_out <= PAD_RGB;
      else
        rgb_out <= s1_rgb;
    end
  end

  obst_hit_acc u_hit_acc (
    .clk        (clk),
    .rst        (rst),
    .active     (s1_active),
    .in_obst    (s1_in_obst),
    .in_pad     (s1_in_pad),
    .in_obj     (s1_in_obj),
    .vblnk      (s1_vblnk),
    .flag_clr   (flag_clr),
    .crash_flag (crash_flag),
    .land_flag  (land_flag),
    .frame_done (frame_done)
  );

endmodule

// File: doc/draw_obstacles_tbl.md
Name: draw_obstacles_tbl

Overview:
- Parametrised, pipelined obstacle overlay for the VGA timing chain; sits after the background stage and before the sprite stage.
- Obstacle rectangles and the landing pad per level come from a constant table, not hard-coded comparisons.
- Paints obstacles, top/bottom borders and the landing pad into the pixel stream.
- Reports once per frame whether the player rectangle overlapped an obstacle (crash) or the landing pad (landing).

Parameters:
- N_OBST, 8, max obstacle rectangles per level (table slots; unused slots have valid=0)
- N_LVL, 3, number of defined levels; level codes 1..N_LVL
- LVL_W, 3, width of lvl input
- OBST_RGB, 12'h000, obstacle and border colour
- PAD_RGB, 12'h0F0, landing pad colour
- BORDER_TOP, 40, rows 0..BORDER_TOP-1 are border
- BORDER_BOT, 580, rows BORDER_BOT..599 are border

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- lvl  in  LVL_W  requested level
- obj_x, obj_y  in  11 each  player rectangle top-left corner
- obj_w, obj_h  in  7 each  player rectangle size; 0 means no player
- hcount_in, vcount_in  in  11 each  pixel coordinates
- hsync_in, hblnk_in, vsync_in, vblnk_in  in  1 each  timing signals
- rgb_in  in  12  upstream pixel
- hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out  out  as inputs  timing delayed by 2 cycles
- rgb_out  out  12  composited pixel
- crash_flag  out  1  sticky crash indicator
- land_flag  out  1  sticky landing indicator
- frame_done  out  1  one-cycle pulse when per-frame results are published
- flag_clr  in  1  clears crash_flag and land_flag

Behaviour:
- Reset: every output is 0, lvl_q=0, accumulators are 0, pipeline registers are 0.
- Latency: 2 cycles for all timing outputs and rgb_out; timing signals are delayed identically.
- Level latch: lvl_q <= lvl on the rising edge of vblnk_in (vblnk_in=1 and its previous value 0). A lvl change mid-frame has no visible effect until the next frame.
- Invalid lvl_q (0 or >N_LVL) means pure pass-through: no borders, no pad, no flags set.
- Stage 1 registers these bits:
  - in_obst = border rows OR any valid rectangle for lvl_q, using half-open bounds x <= h < x+w and y <= v < y+h.
  - in_pad = pixel inside the pad rectangle.
  - in_obj = obj_w != 0, obj_h != 0, and the pixel is inside the obj rectangle.
- Stage 1 also registers the timing signals and rgb_in.
- Bounds arithmetic is done in 12 bits so that x+w never wraps.
- Stage 2 colour priority: in_obst -> OBST_RGB; else in_pad -> PAD_RGB; else rgb from stage 1.
- Colour is applied only when the stage-1 hblnk and vblnk are both 0; blanked pixels pass through.
- Accumulators:
  - crash_acc |= in_obst & in_obj on stage-2 active pixels.
  - land_acc |= in_pad & in_obj & ~in_obst on stage-2 active pixels.
- Publish event: rising edge of the stage-2 vblnk.
  - frame_done=1 for exactly one cycle.
  - crash_flag |= crash_acc and land_flag |= land_acc.
  - Both accumulators clear in the same cycle.
- An accumulating pixel in the publish cycle counts toward the frame being closed.
- flag_clr coinciding with a publish event: the publish wins, so the flags equal the accumulators. Otherwise flag_clr zeroes both flags next cycle.
- Reset mid-frame: accumulators are discarded; the first publish after reset reports only pixels seen after reset.
- The obj inputs are sampled per pixel. Upstream holds them stable during active video; the block does not register them.

Decomposition:
- Package obstacles_pkg holds:
  - rect_t (x, y, w, h in 11 bits; valid in 1 bit).
  - Level table LVL_TBL[N_LVL][N_OBST] and PAD_TBL[N_LVL].
  - Border constants and the in_rect function.
- Level 1 table contents: (200,250,150,20), (450,150,150,20), (200,530,70,60), (280,490,60,100). Pad: (630,550,115,20).
- One sub-module, obst_hit_acc, implements the accumulators, the publish edge detect and the sticky flags.

Test Plan:
- Pipeline and pass-through: rst, then lvl=1 with no vblnk edge yet; rgb_in=12'hABC at (200,250) -> rgb_out=12'hABC 2 cycles later, timing outputs equal to inputs delayed 2.
- Obstacle edges: lvl_q=1. (200,250) -> 12'h000; (349,269) -> 12'h000; (350,250) -> rgb_in; (200,270) -> rgb_in; (100,20) -> 12'h000 (border).
- Crash flag: obj=(210,255,10,10) during the frame -> at the vblnk rise frame_done pulses 1 cycle and crash_flag=1, land_flag=0. The next frame with obj=(100,100,10,10) keeps crash_flag=1 (sticky) until flag_clr.
- Landing pad: obj=(640,545,20,10) -> pixel (640,560) shows 12'h0F0; on publish land_flag=1, crash_flag=0.
- Level switch mid-frame: lvl 1->2 at vcount=300 -> the rest of the frame uses level 1 rectangles; the next frame uses level 2. lvl=0 -> pass-through everywhere, including rows 0..39.
- Simultaneous events: flag_clr asserted in the publish cycle with crash_acc=1 -> crash_flag=1. Reset asserted at vcount=300 -> all outputs 0 next cycle and the next publish reports only pixels seen after reset.
